// File: rtl/seq_recog_pkg.sv
// Shared constants and helpers for the serial pattern recognizer.
// Mode encodings for overlap_en and the fill-counter width helper.
package seq_recog_pkg;

    localparam logic MODE_NONOVERLAP = 1'b0;
    localparam logic MODE_OVERLAP    = 1'b1;

    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a HOLD-cycle registered level.
// A trigger while active reloads the hold count rather than extending it.
module pulse_stretcher #(
    parameter int HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic out
);

    localparam int HW = $clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_next;
    logic          r_out;

    always_comb begin
        w_hold_next = r_hold;
        if (trig) begin
            w_hold_next = HOLD_V;
        end else if (r_hold != '0) begin
            w_hold_next = r_hold - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_out  <= 1'b0;
        end else begin
            r_hold <= w_hold_next;
            r_out  <= (w_hold_next != '0);
        end
    end

    assign out = r_out;

endmodule

// File: rtl/seq_pattern_recognizer.sv
// Serial PAT_LEN-bit pattern detector with match pulse, stretched LED
// drive and saturating match counter.
module seq_pattern_recognizer
    import seq_recog_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0011,
    parameter int                 HOLD    = 8,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             overlap_en,
    input  logic             clear_count,
    output logic             match,
    output logic             led,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = fill_width(PAT_LEN);
    localparam logic [FW-1:0]    FULL    = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] r_window;
    logic [FW-1:0]      r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;

    logic [PAT_LEN-1:0] w_window_next;
    logic [FW-1:0]      w_fill_next;
    logic               w_hit;

    assign w_window_next = {r_window[PAT_LEN-2:0], bit_in};
    assign w_fill_next   = (r_fill == FULL) ? FULL : r_fill + 1'b1;
    assign w_hit = bit_valid && (w_fill_next == FULL)
                 && (w_window_next == PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window <= '0;
            r_fill   <= '0;
            r_match  <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (bit_valid) begin
                r_window <= w_window_next;
                // A non-overlapping hit consumes the whole window.
                if (w_hit && overlap_en == MODE_NONOVERLAP) begin
                    r_fill <= '0;
                end else begin
                    r_fill <= w_fill_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear_count) begin
            r_count <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && r_count != CNT_MAX) begin
            r_count <= r_count + 1'b1;
        end
    end

    pulse_stretcher #(
        .HOLD (HOLD)
    ) u_led (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (w_hit),
        .out   (led)
    );

    assign match       = r_match;
    assign match_count = r_count;

endmodule
